// File: rtl/rot_sweep_pkg.sv
// Shared types, constants and the rotate helper for the rotate-sweep driver.
package rot_sweep_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int DEFAULT_WIDTH = 4;
   localparam int ROT_MAX_W     = 32;
   localparam int ROT_IDX_W     = $clog2(ROT_MAX_W);

   // Left-rotate the low w bits of d by a (a < w); bits at or above w come back zero.
   function automatic logic [ROT_MAX_W-1:0] rotl(input logic [ROT_MAX_W-1:0] d,
                                                 input int a,
                                                 input int w);
      logic [ROT_MAX_W-1:0] r;
      r = '0;
      for (int i = 0; i < ROT_MAX_W; i++) begin
         if (i < w) r[ROT_IDX_W'((i + a) % w)] = d[ROT_IDX_W'(i)];
      end
      return r;
   endfunction

endpackage

// File: rtl/rotl_word.sv
// Combinational left rotate of a WIDTH-bit word by amt positions.
module rotl_word
   import rot_sweep_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   localparam int AMT_W = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] d_i,
   input  logic [AMT_W-1:0] amt_i,
   output logic [WIDTH-1:0] q_o
);

   assign q_o = WIDTH'(rotl(ROT_MAX_W'(d_i), int'(amt_i), WIDTH));

endmodule

// File: rtl/rot_sweep_ctrl.sv
// Accepts one word and streams its left rotations, amount stepping by one per beat.
// Handshake: a transfer happens on a rising edge where valid and ready are both high;
// the producer holds valid and its payload stable until that edge.
module rot_sweep_ctrl
   import rot_sweep_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   localparam int AMT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [AMT_W-1:0] in_amt,
   input  logic [AMT_W-1:0] in_count,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [AMT_W-1:0] out_amt,
   output logic             out_last,
   output logic             dbg_state
);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [AMT_W-1:0] amt_q, amt_d;
   logic [AMT_W-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic             out_valid_q, out_valid_d;
   logic             out_last_q, out_last_d;

   logic [WIDTH-1:0] rot_src;
   logic [AMT_W-1:0] rot_amt;
   logic [WIDTH-1:0] rot_res;

   // The rotator always computes the beat that would be loaded next.
   assign rot_src = (state_q == IDLE) ? in_data : data_q;
   assign rot_amt = (state_q == IDLE) ? in_amt : amt_q + AMT_W'(1);

   rotl_word #(.WIDTH(WIDTH)) u_rotl (
      .d_i   (rot_src),
      .amt_i (rot_amt),
      .q_o   (rot_res)
   );

   always_comb begin
      state_d     = state_q;
      data_d      = data_q;
      amt_d       = amt_q;
      rem_d       = rem_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_d     = RUN;
               data_d      = in_data;
               amt_d       = in_amt;
               rem_d       = in_count;
               out_data_d  = rot_res;
               out_valid_d = 1'b1;
               out_last_d  = (in_count == '0);
            end
         end
         RUN: begin
            if (out_ready) begin
               if (out_last_q) begin
                  state_d     = IDLE;
                  out_valid_d = 1'b0;
               end else begin
                  amt_d      = rot_amt;
                  rem_d      = rem_q - AMT_W'(1);
                  out_data_d = rot_res;
                  out_last_d = (rem_q == AMT_W'(1));
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         data_q      <= '0;
         amt_q       <= '0;
         rem_q       <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         data_q      <= data_d;
         amt_q       <= amt_d;
         rem_q       <= rem_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
      end
   end

   assign in_ready  = (state_q == IDLE) && !rst;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_amt   = amt_q;
   assign out_last  = out_last_q;
   assign dbg_state = (state_q == RUN);

endmodule

// File: tb/tb_rot_sweep_ctrl.sv
// Directed bench for rot_sweep_ctrl: reset, sweeps, wrap, backpressure, ignored input, mid-burst reset.
module tb_rot_sweep_ctrl;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_data;
   logic [1:0] in_amt;
   logic [1:0] in_count;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_data;
   logic [1:0] out_amt;
   logic       out_last;
   logic       dbg_state;

   int total = 0;
   int bad   = 0;

   rot_sweep_ctrl #(.WIDTH(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_amt    (in_amt),
      .in_count  (in_count),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_amt   (out_amt),
      .out_last  (out_last),
      .dbg_state (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic beat(input string tag, input logic [3:0] d, input logic [1:0] a, input logic l);
      chk({tag, "_valid"}, 32'(out_valid), 32'(1'b1));
      chk({tag, "_data"},  32'(out_data),  32'(d));
      chk({tag, "_amt"},   32'(out_amt),   32'(a));
      chk({tag, "_last"},  32'(out_last),  32'(l));
      chk({tag, "_inrdy"}, 32'(in_ready),  32'(1'b0));
   endtask

   task automatic idle_chk(input string tag);
      chk({tag, "_valid"}, 32'(out_valid), 32'(1'b0));
      chk({tag, "_inrdy"}, 32'(in_ready),  32'(1'b1));
      chk({tag, "_state"}, 32'(dbg_state), 32'(1'b0));
   endtask

   task automatic send(input logic [3:0] d, input logic [1:0] a, input logic [1:0] c);
      in_valid = 1'b1;
      in_data  = d;
      in_amt   = a;
      in_count = c;
      tick();
      in_valid = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_amt    = '0;
      in_count  = '0;
      out_ready = 1'b1;

      // reset
      tick();
      tick();
      chk("rst_valid", 32'(out_valid), 32'(1'b0));
      chk("rst_data",  32'(out_data),  32'(4'b0000));
      chk("rst_amt",   32'(out_amt),   32'(2'd0));
      chk("rst_last",  32'(out_last),  32'(1'b0));
      chk("rst_inrdy", 32'(in_ready),  32'(1'b0));
      chk("rst_state", 32'(dbg_state), 32'(1'b0));
      rst = 1'b0;
      #1;
      chk("rel_inrdy", 32'(in_ready), 32'(1'b1));
      tick();
      idle_chk("rel");

      // full sweep
      send(4'b1101, 2'd0, 2'd3);
      beat("sw0", 4'b1101, 2'd0, 1'b0);
      tick();
      beat("sw1", 4'b1011, 2'd1, 1'b0);
      tick();
      beat("sw2", 4'b0111, 2'd2, 1'b0);
      tick();
      beat("sw3", 4'b1110, 2'd3, 1'b1);
      tick();
      idle_chk("sw_end");
      chk("sw_hold_data", 32'(out_data), 32'(4'b1110));

      // wrap
      send(4'b1101, 2'd3, 2'd1);
      beat("wr0", 4'b1110, 2'd3, 1'b0);
      tick();
      beat("wr1", 4'b1101, 2'd0, 1'b1);
      tick();
      idle_chk("wr_end");

      // single beat
      send(4'b1101, 2'd2, 2'd0);
      beat("sg0", 4'b0111, 2'd2, 1'b1);
      tick();
      idle_chk("sg_end");

      // backpressure on beat 1
      send(4'b1101, 2'd0, 2'd3);
      beat("bp0", 4'b1101, 2'd0, 1'b0);
      tick();
      beat("bp1", 4'b1011, 2'd1, 1'b0);
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         beat("bp_hold", 4'b1011, 2'd1, 1'b0);
      end
      out_ready = 1'b1;
      tick();
      beat("bp2", 4'b0111, 2'd2, 1'b0);
      tick();
      beat("bp3", 4'b1110, 2'd3, 1'b1);
      tick();
      idle_chk("bp_end");

      // input presented during a burst is ignored, then accepted afterwards
      send(4'b1101, 2'd0, 2'd3);
      in_valid = 1'b1;
      in_data  = 4'b0001;
      in_amt   = 2'd0;
      in_count = 2'd0;
      beat("ir0", 4'b1101, 2'd0, 1'b0);
      tick();
      beat("ir1", 4'b1011, 2'd1, 1'b0);
      tick();
      beat("ir2", 4'b0111, 2'd2, 1'b0);
      tick();
      beat("ir3", 4'b1110, 2'd3, 1'b1);
      tick();
      idle_chk("ir_gap");
      tick();
      in_valid = 1'b0;
      beat("ir_next", 4'b0001, 2'd0, 1'b1);
      tick();
      idle_chk("ir_end");

      // reset mid-burst, with a competing input handshake
      send(4'b1101, 2'd0, 2'd3);
      beat("mr0", 4'b1101, 2'd0, 1'b0);
      tick();
      beat("mr1", 4'b1011, 2'd1, 1'b0);
      rst      = 1'b1;
      in_valid = 1'b1;
      in_data  = 4'b1111;
      tick();
      chk("mr_valid", 32'(out_valid), 32'(1'b0));
      chk("mr_state", 32'(dbg_state), 32'(1'b0));
      chk("mr_inrdy", 32'(in_ready),  32'(1'b0));
      tick();
      chk("mr_prio_valid", 32'(out_valid), 32'(1'b0));
      rst      = 1'b0;
      in_valid = 1'b0;
      tick();
      idle_chk("mr_idle");
      send(4'b1010, 2'd0, 2'd1);
      beat("mr_n0", 4'b1010, 2'd0, 1'b0);
      tick();
      beat("mr_n1", 4'b0101, 2'd1, 1'b1);
      tick();
      idle_chk("mr_end");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rot_sweep_ctrl.md
# rot_sweep_ctrl

Sequential driver that accepts one data word via a valid/ready handshake and emits a burst of left-rotated copies of it, one per accepted output beat. The rotate amount starts at a requested value and increments by one per beat, wrapping modulo WIDTH. The block sits directly upstream of the team's combinational shift stage and replaces hand-stepped shift-amount stimulus with a registered, back-pressurable stream.

## Interface
- WIDTH, 4: data word width; must be a power of two, at least 2.
- AMT_W, $clog2(WIDTH): rotate-amount and count width; derived, not overridden.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  upstream word available.
- in_ready  output  1  block can accept a word; high only in IDLE.
- in_data  input  WIDTH  word to rotate.
- in_amt  input  AMT_W  first rotate amount.
- in_count  input  AMT_W  beats in the burst minus one, so the burst is 1..WIDTH beats.
- out_valid  output  1  out_data/out_amt/out_last are valid.
- out_ready  input  1  downstream accepts the current beat.
- out_data  output  WIDTH  in_data rotated left by out_amt.
- out_amt  output  AMT_W  rotate amount applied to this beat.
- out_last  output  1  final beat of the burst.

## Operation
- FSM states:
  - IDLE: in_ready=1. An input handshake (in_valid & in_ready) latches in_data, sets the current amount to in_amt and the remaining-beat count to in_count, loads beat 0 into the output register, and moves to RUN.
  - RUN: in_ready=0, out_valid=1. On an output handshake (out_valid & out_ready):
    - if out_last is 1, go to IDLE and clear out_valid;
    - otherwise load the next beat: amount = amount+1 mod WIDTH, remaining = remaining-1.
- Rotation: out_data = (d << a) | (d >> (WIDTH-a)), truncated to WIDTH bits. For a=0 the output equals d.
- out_last = 1 when the remaining count is 0.
- in_valid during RUN is ignored; nothing is buffered.
- While out_valid=1 and out_ready=0, out_data, out_amt and out_last hold stable. Beats are never skipped or duplicated.
- In IDLE, out_data, out_amt and out_last keep their last values with out_valid=0.

## Timing
- Reset: out_valid=0, out_data=0, out_amt=0, out_last=0, state=IDLE. in_ready=0 while rst=1, and 1 from the first cycle after rst is released.
- Latency: input handshake at edge T puts beat 0 on the outputs with out_valid=1 in cycle T+1.
- Throughput: with out_ready held at 1, one beat per cycle.
- Burst turnaround: after the last beat's handshake at edge L, in_ready=1 in cycle L+1. The earliest next input handshake is edge L+1, so there is one idle cycle between bursts.
- Wrap-around: an amount of WIDTH-1 is followed by 0.
- in_count=0 gives a single beat with out_last=1.
- Reset mid-burst: the burst is dropped; out_valid=0 from the next cycle and state=IDLE.
- Reset has priority over any simultaneous handshake.

## Structure
- Shared package rot_sweep_pkg:
  - state enum typedef (IDLE, RUN);
  - default-width constant;
  - rotl function for the rotate expression.
- One combinational sub-module, rotl_word, parameterised by WIDTH. It computes the rotation for the next-beat load path and is instantiated once.
- All registers live in rot_sweep_ctrl. The outputs are driven directly from registers, except in_ready, which is decoded from state and rst.

## Test plan
- Reset: hold rst=1 for 2 cycles -> out_valid=0, out_data=0000, in_ready=0 during reset; in_ready=1 in the first cycle after release.
- Full sweep: in_data=1101, in_amt=0, in_count=3, out_ready=1 -> beats 1101/0, 1011/1, 0111/2, 1110/3 (data/amount) on consecutive cycles starting the cycle after the handshake; out_last only on the 4th; in_ready=1 the cycle after.
- Wrap: in_data=1101, in_amt=3, in_count=1 -> beats 1110/3 then 1101/0 with out_last=1; single beat: in_count=0, in_amt=2 -> 0111/2 with out_last=1.
- Backpressure: full-sweep stimulus with out_ready=0 for 3 cycles while beat 1 is presented -> out_data=1011 and out_amt=1 held stable; sequence resumes at 0111/2 with nothing lost.
- Input during RUN: present in_data=0001 with in_valid=1 during a 1101 burst -> no handshake (in_ready=0) and the burst is unchanged; 0001 is accepted the cycle after the last beat.
- Reset mid-burst: assert rst after beat 1 -> out_valid=0 the next cycle. A following burst with in_data=1010, in_amt=0, in_count=1 yields 1010/0, then 0101/1 with out_last=1.
